// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the 4-bit opcode set.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_OR   = 4'd6,
    OP_NOR  = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_SHL1 = 4'd10,
    OP_SHL2 = 4'd11,
    OP_SHR1 = 4'd12,
    OP_SHR2 = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_mul.sv
// Combinational unsigned WIDTH x WIDTH multiplier with a full 2*WIDTH product.
module alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;

  // Zero-extend both operands so the product keeps every upper bit.
  always_comb begin
    a_ext_s = {{WIDTH{1'b0}}, a};
    b_ext_s = {{WIDTH{1'b0}}, b};
    product = a_ext_s * b_ext_s;
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one opcode-selected result/flag per cycle, one cycle latency.
// The SHL2 flag reads x[WIDTH-2], so WIDTH must be at least 2.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     inc_s;
  logic [WIDTH:0]     dec_s;
  logic [WIDTH-1:0]   res_s;
  logic               flag_s;

  alu_mul #(.WIDTH(WIDTH)) u_mul (
    .a       (x),
    .b       (y),
    .product (product_s)
  );

  // One-bit-wider arithmetic: the extra MSB is the carry or borrow out.
  always_comb begin
    sum_s  = {1'b0, x} + {1'b0, y};
    diff_s = {1'b0, x} - {1'b0, y};
    inc_s  = {1'b0, x} + ONE_EXT;
    dec_s  = {1'b0, x} - ONE_EXT;
  end

  // Select the next result and flag from the opcode; every code is defined.
  always_comb begin
    res_s  = '0;
    flag_s = 1'b0;
    case (alu_op_e'(op))
      OP_PASS: begin res_s = x;                   flag_s = 1'b0;           end
      OP_ADD:  begin res_s = sum_s[WIDTH-1:0];    flag_s = sum_s[WIDTH];   end
      OP_SUB:  begin res_s = diff_s[WIDTH-1:0];   flag_s = diff_s[WIDTH];  end
      OP_MUL:  begin
        res_s  = product_s[WIDTH-1:0];
        flag_s = |product_s[2*WIDTH-1:WIDTH];
      end
      OP_AND:  begin res_s = x & y;               flag_s = 1'b0;           end
      OP_NAND: begin res_s = ~(x & y);            flag_s = 1'b0;           end
      OP_OR:   begin res_s = x | y;               flag_s = 1'b0;           end
      OP_NOR:  begin res_s = ~(x | y);            flag_s = 1'b0;           end
      OP_XOR:  begin res_s = x ^ y;               flag_s = 1'b0;           end
      OP_NOT:  begin res_s = ~x;                  flag_s = 1'b0;           end
      OP_SHL1: begin res_s = x << 1'b1;           flag_s = x[WIDTH-1];     end
      OP_SHL2: begin res_s = x << 2'd2;           flag_s = x[WIDTH-2];     end
      OP_SHR1: begin res_s = x >> 1'b1;           flag_s = x[0];           end
      OP_SHR2: begin res_s = x >> 2'd2;           flag_s = x[1];           end
      OP_INC:  begin res_s = inc_s[WIDTH-1:0];    flag_s = &x;             end
      OP_DEC:  begin res_s = dec_s[WIDTH-1:0];    flag_s = ~(|x);          end
      default: begin res_s = '0;                  flag_s = 1'b0;           end
    endcase
  end

  // Output register; reset wins over whatever op is presented alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      cout <= 1'b0;
    end else begin
      out  <= res_s;
      cout <= flag_s;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at issue, checked one cycle later.
module tb_alu;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] out;
    logic         cout;
    string        tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [3:0]   op;
  logic [W-1:0] out;
  logic         cout;

  exp_t exp_q[$];
  int   total;
  int   bad;

  alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .op   (op),
    .out  (out),
    .cout (cout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Independent integer reference for one operation on WIDTH=4.
  task automatic model(input int a, input int b, input int o, output int r, output int c);
    int t;
    c = 0;
    case (o)
      0:  r = a;
      1:  begin t = a + b; r = t % 16; c = (t > 15) ? 1 : 0; end
      2:  begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      3:  begin t = a * b; r = t % 16; c = (t > 15) ? 1 : 0; end
      4:  r = a & b;
      5:  r = 15 - (a & b);
      6:  r = a | b;
      7:  r = 15 - (a | b);
      8:  r = a ^ b;
      9:  r = 15 - a;
      10: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
      11: begin r = (a * 4) % 16; c = (a / 4) % 2; end
      12: begin r = a / 2; c = a % 2; end
      13: begin r = a / 4; c = (a / 2) % 2; end
      14: begin r = (a + 1) % 16; c = (a == 15) ? 1 : 0; end
      15: begin r = (a + 15) % 16; c = (a == 0) ? 1 : 0; end
      default: r = 0;
    endcase
  endtask

  // Compare the oldest pending expectation against what the DUT now shows.
  task automatic score();
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val({e.tag, "_out"},  {4'd0, out},  {4'd0, e.out});
      check_val({e.tag, "_cout"}, {7'd0, cout}, {7'd0, e.cout});
    end
  endtask

  // At the falling edge: score the previous op, then drive the next one.
  task automatic issue(input logic r, input int a, input int b, input int o,
                       input int eo, input int ec, input string tag);
    exp_t e;
    @(negedge clk);
    score();
    rst = r;
    x   = W'(a);
    y   = W'(b);
    op  = 4'(o);
    e.out  = W'(eo);
    e.cout = ec[0];
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Issue an op whose expectation comes from the reference model.
  task automatic issue_model(input logic r, input int a, input int b, input int o, input string tag);
    int er;
    int ec;
    if (r) begin
      er = 0;
      ec = 0;
    end else begin
      model(a, b, o, er, ec);
    end
    issue(r, a, b, o, er, ec, tag);
  endtask

  // Directed cases first, then a long random run with resets mid-stream.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    x     = '0;
    y     = '0;
    op    = 4'd0;

    // Reset held two cycles with an ADD presented, then released.
    issue(1'b1, 6, 3, 1, 0, 0, "rst0");
    issue(1'b1, 6, 3, 1, 0, 0, "rst1");
    issue(1'b0, 6, 3, 1, 9, 0, "rel_add");

    // Basic sequence on x=6, y=3.
    issue(1'b0, 6, 3, 2,  3, 0, "sub");
    issue(1'b0, 6, 3, 3,  2, 1, "mul");
    issue(1'b0, 6, 3, 6,  7, 0, "or");
    issue(1'b0, 6, 3, 7,  8, 0, "nor");
    issue(1'b0, 6, 3, 11, 8, 1, "shl2");

    // Carry and borrow edges.
    issue(1'b0, 15, 1, 1,  0,  1, "add_wrap");
    issue(1'b0, 3,  6, 2,  13, 1, "sub_borrow");
    issue(1'b0, 15, 0, 14, 0,  1, "inc_wrap");
    issue(1'b0, 0,  0, 15, 15, 1, "dec_wrap");

    // Logic and shift on x=10, y=12.
    issue(1'b0, 10, 12, 4,  8, 0, "and");
    issue(1'b0, 10, 12, 5,  7, 0, "nand");
    issue(1'b0, 10, 12, 8,  6, 0, "xor");
    issue(1'b0, 10, 12, 9,  5, 0, "not");
    issue(1'b0, 10, 12, 10, 4, 1, "shl1");
    issue(1'b0, 10, 12, 12, 5, 0, "shr1");
    issue(1'b0, 10, 12, 13, 2, 1, "shr2");

    // Random back-to-back ops with short resets inserted.
    for (int i = 0; i < 1000; i++) begin
      logic r;
      r = (i == 400 || i == 401 || i == 750) ? 1'b1 : 1'b0;
      issue_model(r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), r ? "rnd_rst" : "rnd");
    end

    // Drain the last expectation and confirm nothing is left over.
    @(negedge clk);
    score();
    check_val("sb_drain", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
